spram_req_ctrl: RTL and testbench

Request/response controller that sits directly upstream of one SB_SPRAM256KA and drives all of its ports. A requester, such as the CPU data path or a test FSM, uses valid/ready handshakes to issue 16-bit word reads and writes. The block sequences the SPRAM's one-cycle read latency and holds read data until the requester accepts it. SLEEP is tied 0 and POWEROFF is tied 1 at the instantiating level.

---
 rtl/spram_req_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_spram_req_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spram_req_ctrl.sv
// spram_req_ctrl
//   Valid/ready request/response front end for a single SB_SPRAM256KA.
//   It accepts one 16-bit word read or write at a time and drives every
//   SPRAM port from a flop. It also handles the one-cycle read latency of
//   the SPRAM and keeps read data stable until the requester accepts it.
//
//   Optional build macro: SPRAM_STANDBY_EN
//     When defined, the controller puts the SPRAM into STANDBY after
//     IDLE_TIMEOUT idle cycles. A new request wakes it, and the controller
//     waits WAKE_CYCLES before accepting that request.
//     When undefined, spram_standby is tied to 0 and no counters are built.
//
// Ports
//   CLK, RST              clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_we/addr/wdata/be  request payload (be[0] = bits 7:0, be[1] = bits 15:8)
//   rsp_valid/rsp_ready   read response handshake; rsp_rdata is held while valid
//   spram_*               registered SPRAM controls, plus spram_dout from the SPRAM
//   busy                  controller is not in IDLE
module spram_req_ctrl #(
  parameter int ADDR_W       = 14,
  parameter int IDLE_TIMEOUT = 255,
  parameter int WAKE_CYCLES  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_rdata,
  output logic [ADDR_W-1:0] spram_addr,
  output logic [15:0]       spram_din,
  output logic [3:0]        spram_maskwren,
  output logic              spram_wren,
  output logic              spram_cs,
  output logic              spram_standby,
  input  logic [15:0]       spram_dout,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_CAPTURE, S_RESP, S_STANDBY, S_WAKE
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [15:0]         rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0]   spram_addr_q, spram_addr_d;
  logic [15:0]         spram_din_q, spram_din_d;
  logic [3:0]          spram_maskwren_q, spram_maskwren_d;
  logic                spram_wren_q, spram_wren_d;
  logic                spram_cs_q, spram_cs_d;

`ifdef SPRAM_STANDBY_EN
  localparam int IDLE_CW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int WAKE_CW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  // The counter stops one short of the timeout. The edge that would reach
  // IDLE_TIMEOUT is the same edge that enters STANDBY.
  localparam logic [IDLE_CW-1:0] IDLE_LAST = IDLE_CW'(IDLE_TIMEOUT - 1);
  localparam logic [WAKE_CW-1:0] WAKE_LAST = WAKE_CW'(WAKE_CYCLES - 1);

  logic                spram_standby_q, spram_standby_d;
  logic [IDLE_CW-1:0]  idle_cnt_q, idle_cnt_d;
  logic [WAKE_CW-1:0]  wake_cnt_q, wake_cnt_d;
`else
  logic                unused_params;
  assign unused_params = (IDLE_TIMEOUT == WAKE_CYCLES);
`endif

  always_comb begin
    state_d          = state_q;
    we_d             = we_q;
    rsp_valid_d      = rsp_valid_q;
    rsp_rdata_d      = rsp_rdata_q;
    spram_addr_d     = spram_addr_q;
    spram_din_d      = spram_din_q;
    spram_maskwren_d = spram_maskwren_q;
    spram_wren_d     = spram_wren_q;
    spram_cs_d       = spram_cs_q;
`ifdef SPRAM_STANDBY_EN
    spram_standby_d  = spram_standby_q;
    idle_cnt_d       = idle_cnt_q;
    wake_cnt_d       = wake_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          // The request goes straight into the SPRAM-facing registers, so
          // the SPRAM sees it during ISSUE.
          spram_addr_d     = req_addr;
          spram_din_d      = req_wdata;
          spram_cs_d       = 1'b1;
          spram_wren_d     = req_we & (|req_be);
          spram_maskwren_d = {req_be[1], req_be[1], req_be[0], req_be[0]};
          we_d             = req_we;
          state_d          = S_ISSUE;
`ifdef SPRAM_STANDBY_EN
          idle_cnt_d       = '0;
`endif
        end
`ifdef SPRAM_STANDBY_EN
        else if (idle_cnt_q == IDLE_LAST) begin
          spram_standby_d = 1'b1;
          idle_cnt_d      = '0;
          state_d         = S_STANDBY;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_CW'(1);
        end
`endif
      end
      S_ISSUE: begin
        spram_cs_d       = 1'b0;
        spram_wren_d     = 1'b0;
        spram_maskwren_d = 4'b0000;
        state_d          = we_q ? S_IDLE : S_CAPTURE;
      end
      S_CAPTURE: begin
        rsp_rdata_d = spram_dout;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
`ifdef SPRAM_STANDBY_EN
      S_STANDBY: begin
        if (req_valid) begin
          spram_standby_d = 1'b0;
          wake_cnt_d      = '0;
          state_d         = S_WAKE;
        end
      end
      S_WAKE: begin
        // The requester keeps the request asserted. IDLE accepts it once
        // the SPRAM has had time to come out of standby.
        if (wake_cnt_q == WAKE_LAST) state_d = S_IDLE;
        else                         wake_cnt_d = wake_cnt_q + WAKE_CW'(1);
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q          <= S_IDLE;
      we_q             <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= '0;
      spram_addr_q     <= '0;
      spram_din_q      <= '0;
      spram_maskwren_q <= '0;
      spram_wren_q     <= 1'b0;
      spram_cs_q       <= 1'b0;
`ifdef SPRAM_STANDBY_EN
      spram_standby_q  <= 1'b0;
      idle_cnt_q       <= '0;
      wake_cnt_q       <= '0;
`endif
    end else begin
      state_q          <= state_d;
      we_q             <= we_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_rdata_q      <= rsp_rdata_d;
      spram_addr_q     <= spram_addr_d;
      spram_din_q      <= spram_din_d;
      spram_maskwren_q <= spram_maskwren_d;
      spram_wren_q     <= spram_wren_d;
      spram_cs_q       <= spram_cs_d;
`ifdef SPRAM_STANDBY_EN
      spram_standby_q  <= spram_standby_d;
      idle_cnt_q       <= idle_cnt_d;
      wake_cnt_q       <= wake_cnt_d;
`endif
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign spram_addr     = spram_addr_q;
  assign spram_din      = spram_din_q;
  assign spram_maskwren = spram_maskwren_q;
  assign spram_wren     = spram_wren_q;
  assign spram_cs       = spram_cs_q;
`ifdef SPRAM_STANDBY_EN
  assign spram_standby  = spram_standby_q;
`else
  assign spram_standby  = 1'b0;
`endif

endmodule

// File: tb/tb_spram_req_ctrl.sv
// Directed bench for spram_req_ctrl, with a behavioural SB_SPRAM256KA model
// driving spram_dout.
module tb_spram_req_ctrl;
  localparam int AW = 14;

  logic          CLK, RST;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [15:0]   req_wdata;
  logic [1:0]    req_be;
  logic          rsp_valid, rsp_ready;
  logic [15:0]   rsp_rdata;
  logic [AW-1:0] spram_addr;
  logic [15:0]   spram_din, spram_dout;
  logic [3:0]    spram_maskwren;
  logic          spram_wren, spram_cs, spram_standby, busy;

  int errs = 0;
  int checks = 0;

`ifdef SPRAM_STANDBY_EN
  spram_req_ctrl #(.ADDR_W(AW), .IDLE_TIMEOUT(4), .WAKE_CYCLES(2)) dut (
`else
  spram_req_ctrl #(.ADDR_W(AW)) dut (
`endif
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .spram_addr(spram_addr), .spram_din(spram_din),
    .spram_maskwren(spram_maskwren), .spram_wren(spram_wren),
    .spram_cs(spram_cs), .spram_standby(spram_standby),
    .spram_dout(spram_dout), .busy(busy)
  );

  // SPRAM model: each maskwren bit enables one nibble of the write.
  // A read updates DATAOUT on the edge and holds it otherwise.
  logic [15:0] mem [0:(1<<AW)-1];
  logic [15:0] bmask;
  assign bmask = {{4{spram_maskwren[3]}}, {4{spram_maskwren[2]}},
                  {4{spram_maskwren[1]}}, {4{spram_maskwren[0]}}};
  initial spram_dout = 16'h0;
  always @(posedge CLK) begin
    if (spram_cs && spram_wren)
      mem[spram_addr] <= (mem[spram_addr] & ~bmask) | (spram_din & bmask);
    else if (spram_cs)
      spram_dout <= mem[spram_addr];
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive a request and return #1 after the edge that accepts it.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [15:0] d,
                      input logic [1:0] be);
    int n = 0;
    @(negedge CLK);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("accept", {31'b0, req_ready}, 32'd1);
    @(posedge CLK);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = 2'b00;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
    send(1'b1, a, d, be);
    chk("wr_cs",   {31'b0, spram_cs}, 32'd1);
    chk("wr_wren", {31'b0, spram_wren}, {31'b0, |be});
    chk("wr_mask", {28'b0, spram_maskwren}, {28'b0, be[1], be[1], be[0], be[0]});
    chk("wr_addr", {18'b0, spram_addr}, {18'b0, a});
    chk("wr_din",  {16'b0, spram_din}, {16'b0, d});
    @(posedge CLK); #1;
    chk("wr_wren_off", {31'b0, spram_wren}, 32'd0);
    chk("wr_cs_off",   {31'b0, spram_cs}, 32'd0);
    chk("wr_mask_off", {28'b0, spram_maskwren}, 32'd0);
    chk("wr_back_idle", {31'b0, req_ready}, 32'd1);
  endtask

  // Read and check latency and data. hold = cycles in RESP with rsp_ready=0.
  task automatic rd(input logic [AW-1:0] a, input logic [15:0] exp, input int hold);
    rsp_ready = (hold == 0);
    send(1'b0, a, 16'h0, 2'b11);
    chk("rd_lat0", {31'b0, rsp_valid}, 32'd0);
    chk("rd_busy", {31'b0, busy}, 32'd1);
    @(posedge CLK); #1;
    chk("rd_lat1", {31'b0, rsp_valid}, 32'd0);
    @(posedge CLK); #1;
    chk("rd_lat2", {31'b0, rsp_valid}, 32'd1);
    chk("rd_data", {16'b0, rsp_rdata}, {16'b0, exp});
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_data",  {16'b0, rsp_rdata}, {16'b0, exp});
      chk("hold_rdy",   {31'b0, req_ready}, 32'd0);
      chk("hold_busy",  {31'b0, busy}, 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    chk("rd_done_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rd_done_rdy",   {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    RST = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = 2'b00; rsp_ready = 1'b1;
    #2 RST = 1'b1;
    #1;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata",     {16'b0, rsp_rdata}, 32'd0);
    chk("rst_addr",      {18'b0, spram_addr}, 32'd0);
    chk("rst_din",       {16'b0, spram_din}, 32'd0);
    chk("rst_ctl",       {25'b0, spram_maskwren, spram_wren, spram_cs, spram_standby}, 32'd0);
    chk("rst_ready",     {31'b0, req_ready}, 32'd1);
    chk("rst_busy",      {31'b0, busy}, 32'd0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;

    // Full write, then read back.
    wr(14'h0007, 16'h0004, 2'b11);
    rd(14'h0007, 16'h0004, 0);

    // Top address and a partial low-byte write.
    wr(14'h3FFF, 16'h1234, 2'b11);
    wr(14'h3FFF, 16'hABCD, 2'b01);
    rd(14'h3FFF, 16'h12CD, 0);

    // Requester stalls the response for 5 cycles, then the next read follows.
    rd(14'h0007, 16'h0004, 5);
    rd(14'h3FFF, 16'h12CD, 0);

    // A write with no byte enables leaves memory unchanged.
    wr(14'h0100, 16'h5555, 2'b11);
    wr(14'h0100, 16'hFFFF, 2'b00);
    rd(14'h0100, 16'h5555, 0);

    // Reset during CAPTURE of a read.
    send(1'b0, 14'h0007, 16'h0, 2'b11);
    @(posedge CLK); #1;
    chk("cap_addr_pre", {18'b0, spram_addr}, 32'h7);
    #2 RST = 1'b1;
    #1;
    chk("cap_rst_addr",  {18'b0, spram_addr}, 32'd0);
    chk("cap_rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("cap_rst_busy",  {31'b0, busy}, 32'd0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("cap_post_valid", {31'b0, rsp_valid}, 32'd0);
    chk("cap_post_ready", {31'b0, req_ready}, 32'd1);

    // Reset after a write is accepted but before its ISSUE edge.
    send(1'b1, 14'h0007, 16'hBEEF, 2'b11);
    chk("abort_cs_pre", {31'b0, spram_cs}, 32'd1);
    RST = 1'b1;
    #1;
    chk("abort_ctl", {26'b0, spram_maskwren, spram_wren, spram_cs}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    rd(14'h0007, 16'h0004, 0);

`ifdef SPRAM_STANDBY_EN
    // Standby entry after 4 idle cycles, then wake on a held request.
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("sb_not_yet", {31'b0, spram_standby}, 32'd0);
    @(posedge CLK); #1;
    chk("sb_entered", {31'b0, spram_standby}, 32'd1);
    chk("sb_ready",   {31'b0, req_ready}, 32'd0);
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h3FFF; req_be = 2'b11;
    @(posedge CLK); #1;
    chk("sb_wake_drop", {31'b0, spram_standby}, 32'd0);
    chk("sb_wake1_rdy", {31'b0, req_ready}, 32'd0);
    @(posedge CLK); #1;
    chk("sb_wake2_rdy", {31'b0, req_ready}, 32'd0);
    @(posedge CLK); #1;
    chk("sb_idle_rdy",  {31'b0, req_ready}, 32'd1);
    rd(14'h3FFF, 16'h12CD, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
